// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge.
//   - apb_state_e : FSM state encoding for the bridge
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - apb_align_word : clears the byte-offset bits of an address
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  // The APB side only issues word-aligned addresses. The helper works on a
  // 64-bit container so that any bus width up to 64 bits can use it; the
  // caller truncates back to its own width.
  function automatic logic [63:0] apb_align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with watchdog expiry for the APB bridge.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset, clears the count
//   clr_i     in   synchronous clear (end of transfer)
//   en_i      in   count one wait cycle this clock
//   expired_o out  this wait cycle brings the count to TIMEOUT
// TIMEOUT = 0 disables expiry; the counter then still counts but never fires.
module apb_wait_timer #(
  parameter  int TIMEOUT = 255,
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] SAT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged on the wait cycle whose increment reaches TIMEOUT, so
  // the transfer sees exactly TIMEOUT low-PREADY ACCESS cycles before abort.
  assign expired_o = WD_EN && en_i && (count_q >= (SAT - CNT_W'(1)));

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator bridge.
// Accepts one command at a time on a valid/ready request port, runs a
// SETUP/ACCESS APB transfer honouring PREADY wait states, and returns the
// result on a valid/ready response port. A wait-state watchdog aborts
// transfers to a slave that never raises PREADY.
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   req_valid/req_ready          command handshake
//   req_write/req_addr/req_wdata command fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_err/rsp_timeout response fields
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA  APB outputs (registered / state decoded)
//   PRDATA/PREADY/PSLVERR        APB inputs
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic              wait_en;
  logic              wait_clr;
  logic              wait_expired;

  // Count only genuine wait cycles; the count is dropped once the response
  // has been consumed so the next transfer starts from zero.
  assign wait_en  = (state_q == ST_ACCESS) && !PREADY;
  assign wait_clr = (state_q == ST_RESP) && rsp_ready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = ADDR_W'(apb_align_word(64'(req_addr)));
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A completing slave takes priority over a watchdog expiry that
        // would land in the same cycle.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (wait_expired) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Handshake and bus-phase outputs decode straight from the state register,
  // so none of them has a combinational path from any input.
  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE     = (state_q == ST_ACCESS);

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "global timeout");
  end

  // One complete transfer against a slave that inserts `waits` low-PREADY
  // cycles. Expected outcome comes from the transfer rules: the slave wins
  // if it answers within TO ACCESS cycles, otherwise the watchdog aborts
  // after exactly TO cycles. Called at a falling edge with the bridge idle.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] prd, input bit slv,
                          input int rsp_delay, input string tag);
    logic [AW-1:0] exp_addr;
    bit            exp_to;
    int            exp_cycles;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    int            cnt;

    exp_addr   = {addr[AW-1:2], 2'b00};
    exp_to     = (TO != 0) && (waits >= TO);
    exp_cycles = exp_to ? TO : waits + 1;
    exp_rd     = (exp_to || wr) ? '0 : prd;
    exp_err    = exp_to ? 1'b1 : slv;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: req_ready=%b expected 1", tag, req_ready);
    end

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge PCLK); @(negedge PCLK);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;

    checks++;
    if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL %s setup_phase: PSEL,PENABLE,req_ready,rsp_valid=%b expected 1000",
               tag, {PSEL, PENABLE, req_ready, rsp_valid});
    end
    checks++;
    if (PADDR !== exp_addr || PWRITE !== wr || PWDATA !== wd) begin
      errors++;
      $display("FAIL %s setup_bus: PADDR=%h PWRITE=%b PWDATA=%h expected %h %b %h",
               tag, PADDR, PWRITE, PWDATA, exp_addr, wr, wd);
    end

    // PREADY during SETUP must be ignored.
    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge PCLK); @(negedge PCLK);
      if (!(PSEL && PENABLE)) break;
      cnt++;
      checks++;
      if (PADDR !== exp_addr || PWRITE !== wr || PWDATA !== wd) begin
        errors++;
        $display("FAIL %s access_stable: PADDR=%h PWRITE=%b PWDATA=%h expected %h %b %h",
                 tag, PADDR, PWRITE, PWDATA, exp_addr, wr, wd);
      end
      PREADY  = (cnt > waits);
      PRDATA  = PREADY ? prd : $urandom;
      PSLVERR = PREADY ? slv : 1'($urandom);
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);

    checks++;
    if (cnt != exp_cycles) begin
      errors++;
      $display("FAIL %s access_cycles: got %0d expected %0d", tag, cnt, exp_cycles);
    end
    checks++;
    if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL %s resp_phase: PSEL,PENABLE,rsp_valid,req_ready=%b expected 0010",
               tag, {PSEL, PENABLE, rsp_valid, req_ready});
    end
    checks++;
    if (rsp_rdata !== exp_rd || rsp_err !== exp_err || rsp_timeout !== exp_to) begin
      errors++;
      $display("FAIL %s resp_fields: rdata=%h err=%b timeout=%b expected %h %b %b",
               tag, rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_to);
    end

    for (int h = 0; h < rsp_delay; h++) begin
      req_valid = 1'($urandom); req_addr = AW'($urandom);
      @(posedge PCLK); @(negedge PCLK);
      checks++;
      if ({rsp_valid, req_ready, PSEL} !== 3'b100 || rsp_rdata !== exp_rd ||
          rsp_err !== exp_err || rsp_timeout !== exp_to) begin
        errors++;
        $display("FAIL %s resp_hold: valid,ready,PSEL=%b rdata=%h err=%b to=%b expected 100 %h %b %b",
                 tag, {rsp_valid, req_ready, PSEL}, rsp_rdata, rsp_err, rsp_timeout,
                 exp_rd, exp_err, exp_to);
      end
    end

    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, PSEL, PENABLE} !== 4'b0100) begin
      errors++;
      $display("FAIL %s resp_release: rsp_valid,req_ready,PSEL,PENABLE=%b expected 0100",
               tag, {rsp_valid, req_ready, PSEL, PENABLE});
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, req_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: PSEL,PENABLE,PWRITE,rsp_valid,rsp_err,rsp_timeout,req_ready=%b expected 0000001",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, req_ready});
    end
    checks++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: PADDR=%h PWDATA=%h rsp_rdata=%h expected 0 0 0", PADDR, PWDATA, rsp_rdata);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_write_zero_wait();
    run_xfer(1'b1, 12'h004, 32'h0000_00A5, 0, 32'h1357_9BDF, 1'b0, 1, "write_zero_wait");
  endtask

  task automatic test_read_wait_states();
    run_xfer(1'b0, 12'h010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0, "read_3_waits");
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 12'h022, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 2, "slverr_read");
    run_xfer(1'b0, 12'h024, 32'h0, 1, 32'h600D_600D, 1'b0, 0, "after_slverr");
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 12'h030, 32'h0, 20, 32'hFFFF_FFFF, 1'b0, 1, "timeout_hang");
    run_xfer(1'b1, 12'h034, 32'h1111_2222, TO, 32'h0, 1'b0, 0, "timeout_exact");
    run_xfer(1'b0, 12'h038, 32'h0, TO - 1, 32'hA5A5_5A5A, 1'b0, 0, "ready_on_last");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd_hold;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h040; req_wdata = 32'hCAFE_0001;
    @(posedge PCLK); @(negedge PCLK);
    // Second command waits on the port while the first is in flight.
    req_write = 1'b0; req_addr = 12'h046; req_wdata = 32'h0;
    PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, req_ready} !== 3'b110 || PADDR !== 12'h040) begin
      errors++;
      $display("FAIL b2b_access: PSEL,PENABLE,req_ready=%b PADDR=%h expected 110 040",
               {PSEL, PENABLE, req_ready}, PADDR);
    end
    @(posedge PCLK); @(negedge PCLK);
    PREADY = 1'b0;
    rd_hold = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_resp1: rsp_valid=%b rsp_err=%b rsp_rdata=%h expected 1 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); @(negedge PCLK);
      checks++;
      if ({req_ready, rsp_valid, PSEL} !== 3'b010 || rsp_rdata !== rd_hold || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall: req_ready,rsp_valid,PSEL=%b rdata=%h err=%b expected 010 %h 0",
                 {req_ready, rsp_valid, PSEL}, rsp_rdata, rsp_err, rd_hold);
      end
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, PSEL} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_idle: req_ready,rsp_valid,PSEL=%b expected 100", {req_ready, rsp_valid, PSEL});
    end
    @(posedge PCLK); @(negedge PCLK);
    req_valid = 1'b0;
    checks++;
    if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 12'h044 || PWRITE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_setup: PSEL,PENABLE=%b PADDR=%h PWRITE=%b expected 10 044 0",
               {PSEL, PENABLE}, PADDR, PWRITE);
    end
    PREADY = 1'b1; PRDATA = 32'hCAFE_BABE; PSLVERR = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    @(posedge PCLK); @(negedge PCLK);
    PREADY = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_BABE || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp2: rsp_valid=%b rdata=%h err=%b expected 1 cafebabe 0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h050; req_wdata = 32'h0;
    @(posedge PCLK); @(negedge PCLK);
    req_valid = 1'b0; PREADY = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset_pre: PSEL,PENABLE=%b expected 11", {PSEL, PENABLE});
    end
    @(posedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000 || PADDR !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: PSEL,PENABLE,rsp_valid=%b PADDR=%h expected 000 0",
               {PSEL, PENABLE, rsp_valid}, PADDR);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    // A late slave acknowledge must not resurrect the dropped transfer.
    PREADY = 1'b1; PRDATA = 32'h5A5A_5A5A;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); @(negedge PCLK);
      checks++;
      if ({req_ready, rsp_valid, PSEL} !== 3'b100) begin
        errors++;
        $display("FAIL mid_reset_after: req_ready,rsp_valid,PSEL=%b expected 100", {req_ready, rsp_valid, PSEL});
      end
    end
    PREADY = 1'b0;
    run_xfer(1'b1, 12'h05C, 32'h0F0F_0F0F, 2, 32'h0, 1'b0, 0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_xfer(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 11)),
               $urandom, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
